apb_adv_timer_input_stage: RTL



---
 rtl/apb_adv_timer_input_pkg.sv | 16 +
 rtl/apb_adv_timer_input_ch.sv | 61 ++++++
 rtl/apb_adv_timer_input_stage.sv | 45 ++++
 3 files changed

// File: rtl/apb_adv_timer_input_pkg.sv
// apb_adv_timer_input_pkg: detect modes and shared widths for the timer external-signal input stage.
package apb_adv_timer_input_pkg;
  localparam int NUM_EXT_DEF = 32;
  localparam int SEL_W = $clog2(NUM_EXT_DEF);
  typedef enum logic [2:0] {
    RISE = 3'd0,
    FALL = 3'd1,
    BOTH = 3'd2,
    HIGH = 3'd3,
    LOW  = 3'd4
  } adv_timer_in_mode_t;
  localparam logic [2:0] MODE_RSVD_LO = 3'd5;
  function automatic logic mode_reserved(input logic [2:0] m);
    return m >= MODE_RSVD_LO;
  endfunction
endpackage

// File: rtl/apb_adv_timer_input_ch.sv
// apb_adv_timer_input_ch: one channel - bit select, edge/level detect, config-change guard, event counter.
module apb_adv_timer_input_ch
  import apb_adv_timer_input_pkg::*;
#(
  parameter int NUM_EXT = 32,
  parameter int CNT_W   = 16
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [NUM_EXT-1:0] sync_i,
  input  logic               en_i,
  input  logic [SEL_W-1:0]   sel_i,
  input  logic [2:0]         mode_i,
  input  logic               clr_i,
  output logic               evt_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               ovf_o
);
  logic s, chg, det, hit;
  logic p_q, p_d, evt_q, evt_d, ovf_q, ovf_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [2:0] mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign s = sync_i[sel_i];
  always_comb begin
    chg = (sel_i != sel_q) || (mode_i != mode_q);
    det = (mode_i == RISE) ? (s & ~p_q) :
          (mode_i == FALL) ? (~s & p_q) :
          (mode_i == BOTH) ? (s ^ p_q) :
          (mode_i == HIGH) ? s :
          (mode_i == LOW)  ? ~s : 1'b0;
    hit = en_i && !chg && !mode_reserved(mode_i) && det;
    p_d = s;
    sel_d = sel_i;
    mode_d = mode_i;
    evt_d = hit;
    // clear wins over a same-cycle increment; the pulse itself still goes out
    cnt_d = clr_i ? '0 : hit ? cnt_q + 1'b1 : cnt_q;
    ovf_d = !clr_i && (ovf_q || (hit && &cnt_q));
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      p_q    <= 1'b0;
      sel_q  <= '0;
      mode_q <= '0;
      evt_q  <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      p_q    <= p_d;
      sel_q  <= sel_d;
      mode_q <= mode_d;
      evt_q  <= evt_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end
  assign evt_o = evt_q;
  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/apb_adv_timer_input_stage.sv
// apb_adv_timer_input_stage: shared synchronizer for ext_sig_i feeding NUM_CH independent event channels.
module apb_adv_timer_input_stage
  import apb_adv_timer_input_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int NUM_EXT     = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [NUM_EXT-1:0]      ext_sig_i,
  input  logic                    dft_cg_enable_i,
  input  logic [NUM_CH-1:0]       cfg_en_i,
  input  logic [NUM_CH*SEL_W-1:0] cfg_sel_i,
  input  logic [NUM_CH*3-1:0]     cfg_mode_i,
  input  logic [NUM_CH-1:0]       cfg_clr_i,
  output logic [NUM_CH-1:0]       evt_o,
  output logic [NUM_CH*CNT_W-1:0] evt_cnt_o,
  output logic [NUM_CH-1:0]       evt_ovf_o
);
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be 2..4");
  end
  logic [SYNC_STAGES-1:0][NUM_EXT-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], ext_sig_i};
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) sync_q <= '0;
    else sync_q <= sync_d;
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    apb_adv_timer_input_ch #(.NUM_EXT(NUM_EXT), .CNT_W(CNT_W)) u_ch (
      .HCLK   (HCLK),
      .HRESETn(HRESETn),
      .sync_i (sync_q[SYNC_STAGES-1]),
      .en_i   (cfg_en_i[c] | dft_cg_enable_i),
      .sel_i  (cfg_sel_i[c*SEL_W +: SEL_W]),
      .mode_i (cfg_mode_i[c*3 +: 3]),
      .clr_i  (cfg_clr_i[c]),
      .evt_o  (evt_o[c]),
      .cnt_o  (evt_cnt_o[c*CNT_W +: CNT_W]),
      .ovf_o  (evt_ovf_o[c])
    );
  end
endmodule
